thor2024_reg_scoreboard: RTL and testbench
==========================================

// Module: thor2024_reg_scoreboard
// PURPOSE
//  Issue-gate stage directly downstream of the Rt/Ra/Rb/Rc decoders.
//  Tracks outstanding writes per architectural register (pending counters).
//  Holds a decoded instruction until its sources have no pending writes and
//  its target counter has room. Passes it through a one-entry issue register
//  to the execute stage. Rt=0 from the decoder means "no target" and is never tracked.
// PARAMETERS
//  NREGS  64  architectural registers (regspec_t index range)
//  REGW   6   register specifier width
//  CNTW   2   pending-counter width; max outstanding writes per reg = 2**CNTW-1
//  NWB    2   writeback ports
//  INSTW  40  instruction width
// PORTS
//  clk       in   1          clock, all state on rising edge
//  rst_n     in   1          asynchronous active-low reset
//  flush     in   1          sync pipeline flush, clears all state
//  dec_valid in   1          decoded instruction present
//  dec_ready out  1          stage accepts dec_* this cycle
//  dec_ir    in   INSTW      instruction word
//  dec_Rt    in   REGW       target reg (0 = none)
//  dec_Ra    in   REGW       source A (0 = unused/r0)
//  dec_Rb    in   REGW       source B
//  dec_Rc    in   REGW       source C
//  iss_valid out  1          issue register holds an instruction
//  iss_ready in   1          execute consumes iss_* this cycle
//  iss_ir    out  INSTW      issued instruction
//  iss_Rt    out  REGW       issued target reg
//  wb_v      in   NWB        writeback strobes
//  wb_Rt     in   NWB*REGW   writeback target regs, port i at [i*REGW+:REGW]
//  sb_err    out  1          sticky: writeback to a reg with zero pending count
// BEHAVIOUR
//  Reset (rst_n=0, async): all counters 0, iss_valid=0, iss_ir=0, iss_Rt=0, sb_err=0.
//  dec_ready is combinational from registered state only:
//    src_ok = cnt[Ra]==0 & cnt[Rb]==0 & cnt[Rc]==0 (register 0 always counts as 0)
//    tgt_ok = (Rt==0) | cnt[Rt] != 2**CNTW-1
//    dec_ready = src_ok & tgt_ok & (!iss_valid | iss_ready) & !flush
//  Writebacks do not bypass the hazard check. A writeback in cycle N unblocks
//  issue in cycle N+1.
//  Issue (dec_valid & dec_ready):
//    - the next edge loads iss_ir/iss_Rt and sets iss_valid=1
//    - cnt[Rt] += 1 when Rt != 0
//  iss_valid drops when iss_ready=1 and no new issue occurs in that cycle.
//  Back-to-back issue at 1/cycle is supported. Issue latency is 1 cycle.
//  Counter update per reg r each cycle: cnt[r] += inc - dec, where
//    - inc = issue with Rt==r (0/1)
//    - dec = number of wb ports i with wb_v[i] & wb_Rt_i==r & r!=0 (0..NWB)
//  Simultaneous inc and dec on the same reg net correctly, e.g. cnt 1, inc 1, dec 1 -> 1.
//  Underflow: if dec exceeds cnt[r]+inc, cnt[r] saturates at 0 and sb_err sets.
//  sb_err clears only on reset.
//  Writeback to r0 is ignored and never sets sb_err.
//  Overflow cannot occur because tgt_ok blocks issue at the maximum count.
//  flush=1:
//    - next edge clears all counters and iss_valid
//    - flush overrides a same-cycle issue and all writebacks
//    - sb_err is kept
//  dec_ready=0 during flush.
//  Reset asserted mid-operation: state clears immediately, regardless of clk.
// TESTING
//  T1 reset: rst_n=0 with random inputs -> iss_valid=0, sb_err=0, dec_ready=1 for dec_valid with Ra=Rb=Rc=Rt=5.
//  T2 RAW: issue Rt=7, then Ra=7 -> dec_ready=0. wb_v[0]=1, wb_Rt=7 in cycle N -> dec_ready=1 in N+1, not N.
//  T3 saturation: CNTW=2, issue Rt=9 three times -> cnt=3, 4th Rt=9 stalls. One wb Rt=9 -> issues next cycle.
//  T4 simultaneous: cnt[12]=2, issue Rt=12 + wb port0 and port1 on 12 same cycle -> cnt[12]=1, sb_err=0.
//  T5 backpressure: iss_ready=0 with iss_valid=1 -> dec_ready=0, iss_ir held stable. iss_ready=1 -> 1 issue/cycle for 8 instrs.
//  T6 flush/error: flush with cnt[3]=2, iss_valid=1 -> next cycle all cnt=0, iss_valid=0. wb Rt=3 -> sb_err=1, stays until rst_n.

Source files
------------

// File: rtl/thor2024_reg_scoreboard.sv
// thor2024_reg_scoreboard: issue gate between decode and execute.
// Counts outstanding writes per register and holds hazarded instructions.
module thor2024_reg_scoreboard #(
  parameter int NREGS = 64,
  parameter int REGW  = 6,
  parameter int CNTW  = 2,
  parameter int NWB   = 2,
  parameter int INSTW = 40
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [INSTW-1:0]     dec_ir,
  input  logic [REGW-1:0]      dec_Rt,
  input  logic [REGW-1:0]      dec_Ra,
  input  logic [REGW-1:0]      dec_Rb,
  input  logic [REGW-1:0]      dec_Rc,
  output logic                 iss_valid,
  input  logic                 iss_ready,
  output logic [INSTW-1:0]     iss_ir,
  output logic [REGW-1:0]      iss_Rt,
  input  logic [NWB-1:0]       wb_v,
  input  logic [NWB*REGW-1:0]  wb_Rt,
  output logic                 sb_err
);

  localparam int SW = CNTW + $clog2(NWB + 1) + 1;
  localparam logic [CNTW-1:0] CMAX = '1;

  typedef struct packed {
    logic             v;
    logic [INSTW-1:0] ir;
    logic [REGW-1:0]  rt;
  } iss_t;

  logic [CNTW-1:0] cnt    [NREGS];
  logic [CNTW-1:0] cnt_nx [NREGS];
  iss_t            iss_q, iss_d;
  logic            err_q, err_d;

  logic [CNTW-1:0] ca, cb, cc, ct;
  logic            src_ok, tgt_ok, issue;
  logic [SW-1:0]   sum, dsum;

  // r0 is never tracked, so its count reads as zero
  assign ca = (dec_Ra == '0) ? '0 : cnt[dec_Ra];
  assign cb = (dec_Rb == '0) ? '0 : cnt[dec_Rb];
  assign cc = (dec_Rc == '0) ? '0 : cnt[dec_Rc];
  assign ct = (dec_Rt == '0) ? '0 : cnt[dec_Rt];

  assign src_ok = (ca == '0) & (cb == '0) & (cc == '0);
  assign tgt_ok = (dec_Rt == '0) | (ct != CMAX);

  assign dec_ready = src_ok & tgt_ok
                   & (!iss_q.v | iss_ready)
                   & !flush;
  assign issue = dec_valid & dec_ready;

  always_comb begin
    err_d = err_q;
    sum   = '0;
    dsum  = '0;
    for (int r = 0; r < NREGS; r++) begin
      sum = SW'(cnt[r]);
      if (issue && dec_Rt == REGW'(r))
        sum = sum + SW'(1);
      dsum = '0;
      for (int i = 0; i < NWB; i++)
        if (wb_v[i] && wb_Rt[i*REGW +: REGW] == REGW'(r))
          dsum = dsum + SW'(1);
      if (r == 0) begin
        cnt_nx[r] = '0;
      end else if (dsum > sum) begin
        cnt_nx[r] = '0;
        err_d     = 1'b1;
      end else begin
        cnt_nx[r] = CNTW'(sum - dsum);
      end
    end
  end

  // issue implies !flush, so the arms are mutually exclusive
  always_comb begin
    iss_d = iss_q;
    unique case (1'b1)
      flush: iss_d.v = 1'b0;
      issue: iss_d = '{v: 1'b1, ir: dec_ir, rt: dec_Rt};
      iss_ready && !issue && !flush: iss_d.v = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++)
        cnt[r] <= '0;
      iss_q <= '0;
      err_q <= 1'b0;
    end else begin
      iss_q <= iss_d;
      if (!flush)
        err_q <= err_d;
      for (int r = 0; r < NREGS; r++)
        cnt[r] <= flush ? '0 : cnt_nx[r];
    end
  end

  assign iss_valid = iss_q.v;
  assign iss_ir    = iss_q.ir;
  assign iss_Rt    = iss_q.rt;
  assign sb_err    = err_q;

endmodule

// File: tb/tb_thor2024_reg_scoreboard.sv
// tb_thor2024_reg_scoreboard: directed scenarios plus random traffic
// against a per-register pending-count model.
module tb_thor2024_reg_scoreboard;
  localparam int NREGS = 64;
  localparam int REGW  = 6;
  localparam int NWB   = 2;
  localparam int INSTW = 40;
  localparam int CMAX  = 3;

  logic clk = 1'b0;
  logic rst_n, flush, dec_valid, dec_ready;
  logic iss_valid, iss_ready, sb_err;
  logic [INSTW-1:0] dec_ir, iss_ir;
  logic [REGW-1:0] dec_Rt, dec_Ra, dec_Rb, dec_Rc, iss_Rt;
  logic [NWB-1:0] wb_v;
  logic [NWB*REGW-1:0] wb_Rt;

  int tests = 0;
  int fails = 0;

  int              m_cnt [NREGS];
  bit              m_iv;
  logic [INSTW-1:0] m_ir;
  logic [REGW-1:0] m_rt;
  bit              m_err;

  always #5 clk = ~clk;

  thor2024_reg_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_ir(dec_ir), .dec_Rt(dec_Rt), .dec_Ra(dec_Ra),
    .dec_Rb(dec_Rb), .dec_Rc(dec_Rc),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_ir(iss_ir), .iss_Rt(iss_Rt),
    .wb_v(wb_v), .wb_Rt(wb_Rt), .sb_err(sb_err)
  );

  function automatic void m_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_iv = 0;
    m_ir = '0;
    m_rt = '0;
    m_err = 0;
  endfunction

  function automatic bit m_ready();
    logic [REGW-1:0] s [3];
    s[0] = dec_Ra;
    s[1] = dec_Rb;
    s[2] = dec_Rc;
    if (flush) return 0;
    if (m_iv && !iss_ready) return 0;
    for (int k = 0; k < 3; k++)
      if (s[k] != 0 && m_cnt[s[k]] != 0) return 0;
    if (dec_Rt != 0 && m_cnt[dec_Rt] >= CMAX) return 0;
    return 1;
  endfunction

  task automatic idle();
    flush = 0;
    dec_valid = 0;
    dec_ir = '0;
    dec_Rt = '0;
    dec_Ra = '0;
    dec_Rb = '0;
    dec_Rc = '0;
    iss_ready = 1;
    wb_v = '0;
    wb_Rt = '0;
  endtask

  task automatic cycle();
    bit iss;
    int r;
    iss = dec_valid && m_ready();
    @(posedge clk);
    if (flush) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_iv = 0;
    end else begin
      if (iss && dec_Rt != 0) m_cnt[dec_Rt]++;
      for (int i = 0; i < NWB; i++) begin
        if (wb_v[i]) begin
          r = int'(wb_Rt[i*REGW +: REGW]);
          if (r != 0) begin
            if (m_cnt[r] > 0) m_cnt[r]--;
            else m_err = 1;
          end
        end
      end
      if (iss) begin
        m_iv = 1;
        m_ir = dec_ir;
        m_rt = dec_Rt;
      end else if (iss_ready) begin
        m_iv = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic flush_cycle();
    idle();
    flush = 1;
    cycle();
    flush = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    m_reset();
    flush = 1'($urandom);
    dec_valid = 1'($urandom);
    dec_ir = INSTW'({$urandom, $urandom});
    dec_Rt = REGW'($urandom);
    dec_Ra = REGW'($urandom);
    dec_Rb = REGW'($urandom);
    dec_Rc = REGW'($urandom);
    iss_ready = 1'($urandom);
    wb_v = NWB'($urandom);
    wb_Rt = (NWB*REGW)'($urandom);
    repeat (3) @(negedge clk);
    tests++;
    if (iss_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_iss_valid: got %b want 0", iss_valid);
    end
    tests++;
    if (sb_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_sb_err: got %b want 0", sb_err);
    end
    flush = 0;
    dec_valid = 1;
    dec_Rt = 5;
    dec_Ra = 5;
    dec_Rb = 5;
    dec_Rc = 5;
    #1;
    tests++;
    if (dec_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_dec_ready: got %b want 1", dec_ready);
    end
    idle();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_raw();
    logic [INSTW-1:0] ir;
    flush_cycle();
    dec_valid = 1;
    dec_Rt = 7;
    dec_ir = INSTW'({$urandom, $urandom});
    cycle();
    dec_Rt = 0;
    dec_Ra = 7;
    ir = INSTW'({$urandom, $urandom});
    dec_ir = ir;
    #1;
    tests++;
    if (dec_ready !== 1'b0) begin
      fails++;
      $display("FAIL raw_stall: dec_ready=%b want 0", dec_ready);
    end
    wb_v = 2'b01;
    wb_Rt = {6'd0, 6'd7};
    #1;
    tests++;
    if (dec_ready !== 1'b0) begin
      fails++;
      $display("FAIL raw_no_bypass: dec_ready=%b want 0", dec_ready);
    end
    cycle();
    wb_v = '0;
    #1;
    tests++;
    if (dec_ready !== 1'b1) begin
      fails++;
      $display("FAIL raw_release: dec_ready=%b want 1", dec_ready);
    end
    cycle();
    tests++;
    if (iss_valid !== 1'b1 || iss_ir !== ir) begin
      fails++;
      $display("FAIL raw_issue: v=%b ir=%h want 1 %h", iss_valid, iss_ir, ir);
    end
  endtask

  task automatic test_saturation();
    flush_cycle();
    dec_valid = 1;
    dec_Rt = 9;
    for (int i = 0; i < 3; i++) begin
      dec_ir = INSTW'(i + 100);
      #1;
      tests++;
      if (dec_ready !== 1'b1) begin
        fails++;
        $display("FAIL sat_fill%0d: dec_ready=%b want 1", i, dec_ready);
      end
      cycle();
    end
    dec_ir = INSTW'(200);
    #1;
    tests++;
    if (dec_ready !== 1'b0) begin
      fails++;
      $display("FAIL sat_full: dec_ready=%b want 0", dec_ready);
    end
    wb_v = 2'b10;
    wb_Rt = {6'd9, 6'd0};
    #1;
    tests++;
    if (dec_ready !== 1'b0) begin
      fails++;
      $display("FAIL sat_wb_same: dec_ready=%b want 0", dec_ready);
    end
    cycle();
    wb_v = '0;
    #1;
    tests++;
    if (dec_ready !== 1'b1) begin
      fails++;
      $display("FAIL sat_release: dec_ready=%b want 1", dec_ready);
    end
    cycle();
    tests++;
    if (iss_valid !== 1'b1 || iss_Rt !== 6'd9 || iss_ir !== 40'd200) begin
      fails++;
      $display("FAIL sat_issue: v=%b rt=%0d ir=%h", iss_valid, iss_Rt, iss_ir);
    end
  endtask

  task automatic test_simultaneous();
    flush_cycle();
    dec_valid = 1;
    dec_Rt = 12;
    cycle();
    cycle();
    wb_v = 2'b11;
    wb_Rt = {6'd12, 6'd12};
    #1;
    tests++;
    if (dec_ready !== 1'b1) begin
      fails++;
      $display("FAIL simul_ready: dec_ready=%b want 1", dec_ready);
    end
    cycle();
    idle();
    dec_Ra = 12;
    #1;
    tests++;
    if (dec_ready !== 1'b0 || sb_err !== 1'b0) begin
      fails++;
      $display("FAIL simul_net1: ready=%b err=%b want 0 0", dec_ready, sb_err);
    end
    wb_v = 2'b01;
    wb_Rt = {6'd0, 6'd12};
    cycle();
    wb_v = '0;
    #1;
    tests++;
    if (dec_ready !== 1'b1 || sb_err !== 1'b0) begin
      fails++;
      $display("FAIL simul_net0: ready=%b err=%b want 1 0", dec_ready, sb_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [INSTW-1:0] first, exp;
    flush_cycle();
    first = INSTW'({$urandom, $urandom});
    dec_valid = 1;
    dec_ir = first;
    cycle();
    iss_ready = 0;
    dec_ir = ~first;
    #1;
    tests++;
    if (dec_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_stall: dec_ready=%b want 0", dec_ready);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests++;
      if (iss_valid !== 1'b1 || iss_ir !== first) begin
        fails++;
        $display("FAIL bp_hold%0d: v=%b ir=%h want 1 %h", i, iss_valid, iss_ir, first);
      end
    end
    iss_ready = 1;
    for (int i = 0; i < 8; i++) begin
      exp = INSTW'({$urandom, $urandom});
      dec_ir = exp;
      dec_Rt = REGW'(20 + i);
      #1;
      tests++;
      if (dec_ready !== 1'b1) begin
        fails++;
        $display("FAIL b2b_ready%0d: dec_ready=%b want 1", i, dec_ready);
      end
      cycle();
      tests++;
      if (iss_valid !== 1'b1 || iss_ir !== exp || iss_Rt !== REGW'(20 + i)) begin
        fails++;
        $display("FAIL b2b_issue%0d: v=%b ir=%h rt=%0d want %h %0d", i, iss_valid, iss_ir, iss_Rt, exp, 20 + i);
      end
    end
    idle();
    cycle();
    tests++;
    if (iss_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_drain: iss_valid=%b want 0", iss_valid);
    end
  endtask

  task automatic test_flush_err();
    flush_cycle();
    dec_valid = 1;
    dec_Rt = 3;
    cycle();
    cycle();
    flush = 1;
    #1;
    tests++;
    if (dec_ready !== 1'b0 || iss_valid !== 1'b1) begin
      fails++;
      $display("FAIL flush_ready: ready=%b v=%b want 0 1", dec_ready, iss_valid);
    end
    cycle();
    idle();
    dec_Ra = 3;
    dec_Rt = 3;
    #1;
    tests++;
    if (iss_valid !== 1'b0 || dec_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_clear: v=%b ready=%b want 0 1", iss_valid, dec_ready);
    end
    idle();
    wb_v = 2'b11;
    wb_Rt = '0;
    cycle();
    tests++;
    if (sb_err !== 1'b0) begin
      fails++;
      $display("FAIL wb_r0: sb_err=%b want 0", sb_err);
    end
    wb_v = 2'b01;
    wb_Rt = {6'd0, 6'd3};
    cycle();
    wb_v = '0;
    tests++;
    if (sb_err !== 1'b1) begin
      fails++;
      $display("FAIL err_set: sb_err=%b want 1", sb_err);
    end
    repeat (3) cycle();
    flush_cycle();
    tests++;
    if (sb_err !== 1'b1) begin
      fails++;
      $display("FAIL err_sticky: sb_err=%b want 1", sb_err);
    end
    #2;
    rst_n = 0;
    m_reset();
    #1;
    tests++;
    if (sb_err !== 1'b0 || iss_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: err=%b v=%b want 0 0", sb_err, iss_valid);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_random();
    int tk [8];
    int r;
    logic rdy;
    idle();
    for (int n = 0; n < 500; n++) begin
      foreach (tk[i]) tk[i] = 0;
      flush = ($urandom_range(0, 31) == 0);
      dec_valid = 1'($urandom);
      dec_ir = INSTW'({$urandom, $urandom});
      dec_Rt = REGW'($urandom_range(0, 7));
      dec_Ra = $urandom_range(0, 1) ? REGW'($urandom_range(0, 7)) : '0;
      dec_Rb = $urandom_range(0, 2) == 0 ? REGW'($urandom_range(0, 7)) : '0;
      dec_Rc = $urandom_range(0, 3) == 0 ? REGW'($urandom_range(0, 7)) : '0;
      iss_ready = ($urandom_range(0, 3) != 0);
      wb_v = '0;
      wb_Rt = '0;
      for (int i = 0; i < NWB; i++) begin
        if ($urandom_range(0, 1) == 0) begin
          r = $urandom_range(0, 7);
          if (r == 0 || m_cnt[r] - tk[r] > 0) begin
            tk[r]++;
            wb_v[i] = 1'b1;
            wb_Rt[i*REGW +: REGW] = REGW'(r);
          end
        end
      end
      #1;
      rdy = m_ready();
      tests++;
      if (dec_ready !== rdy) begin
        fails++;
        $display("FAIL rnd_ready@%0d: got %b want %b", n, dec_ready, rdy);
      end
      cycle();
      tests++;
      if (iss_valid !== m_iv || sb_err !== m_err
          || (m_iv && (iss_ir !== m_ir || iss_Rt !== m_rt))) begin
        fails++;
        $display("FAIL rnd_state@%0d: v=%b err=%b ir=%h rt=%0d want %b %b %h %0d",
                 n, iss_valid, sb_err, iss_ir, iss_Rt, m_iv, m_err, m_ir, m_rt);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    rst_n = 0;
    m_reset();
    @(negedge clk);
    test_reset();
    test_raw();
    test_saturation();
    test_simultaneous();
    test_back_to_back();
    test_flush_err();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
